// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the mem_responder memory-side protocol responder.
// The LFSR constants are consumed only when MEM_RESP_RAND_LAT_EN is defined.
package mem_resp_pkg;

  localparam int MR_DATA_W = 16;
  localparam int MR_ADDR_W = 16;

  // Right-shifting Galois form of x^8+x^6+x^5+x^4+1.
  localparam logic [7:0] MR_LFSR_SEED = 8'hA5;
  localparam logic [7:0] MR_LFSR_TAPS = 8'hB8;

  typedef enum logic [1:0] {
    MR_IDLE = 2'd0,
    MR_WAIT = 2'd1,
    MR_RESP = 2'd2
  } mr_state_e;

  function automatic logic [7:0] mr_lfsr_step(input logic [7:0] s);
    return {1'b0, s[7:1]} ^ (s[0] ? MR_LFSR_TAPS : 8'h00);
  endfunction

endpackage

// File: rtl/mem_resp_array.sv
// Single-port byte-enabled word store with a registered read port for mem_responder.
module mem_resp_array
  import mem_resp_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic                  re,
  input  logic [1:0]            be,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [MR_DATA_W-1:0]  wdata,
  output logic [MR_DATA_W-1:0]  rdata
);

  logic [MR_DATA_W-1:0] mem [0:(1<<DEPTH_LOG2)-1];

  // NOTE: the word store has no reset so it maps onto block RAM; only the read register is reset.
  always_ff @(posedge clk) begin
    if (we) begin
      if (be[0]) mem[idx][7:0]  <= wdata[7:0];
      if (be[1]) mem[idx][15:8] <= wdata[15:8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[idx];
  end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: accept, wait a programmable latency, access, pulse resp.
// Defining MEM_RESP_RAND_LAT_EN adds 0..3 cycles of LFSR-driven extra latency per transaction.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int LATENCY    = 4,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 read,
  input  logic                 write,
  input  logic [MR_ADDR_W-1:0] address,
  input  logic [MR_DATA_W-1:0] wdata,
  input  logic [1:0]           byte_enable,
  output logic                 resp,
  output logic [MR_DATA_W-1:0] rdata,
  output logic                 busy,
  output logic                 proto_err
);

`ifdef MEM_RESP_RAND_LAT_EN
  localparam int CNT_W = 5;
`else
  localparam int CNT_W = 4;
`endif

  mr_state_e             state, state_next;
  logic [CNT_W-1:0]      cnt, cnt_next, eff_lat;
  logic                  op_wr;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [MR_DATA_W-1:0]  wdata_q;
  logic [1:0]            be_q;
  logic                  drop_seen;

  logic                  req, accept, drop_now;
  logic [DEPTH_LOG2-1:0] idx_in;
  logic                  acc_we, acc_re;
  logic [DEPTH_LOG2-1:0] acc_idx;
  logic [MR_DATA_W-1:0]  acc_wdata;
  logic [1:0]            acc_be;

  logic unused_addr;
  assign unused_addr = ^{address[MR_ADDR_W-1:DEPTH_LOG2+1], address[0]};

  assign idx_in   = address[DEPTH_LOG2:1];
  assign req      = read | write;
  assign accept   = (state == MR_IDLE) && req;
  // Only the first cycle in which the latched request is seen low is an error.
  assign drop_now = (state == MR_WAIT) && !drop_seen && !(op_wr ? write : read);

`ifdef MEM_RESP_RAND_LAT_EN
  logic [7:0] lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= MR_LFSR_SEED;
    else        lfsr <= mr_lfsr_step(lfsr);
  end

  assign eff_lat = CNT_W'(LATENCY) + CNT_W'(lfsr[1:0]);
`else
  assign eff_lat = CNT_W'(LATENCY);
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= MR_IDLE;
    else        state <= state_next;
  end

  // NOTE: each combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    unique case (state)
      MR_IDLE: if (req) state_next = (eff_lat == CNT_W'(1)) ? MR_RESP : MR_WAIT;
      MR_WAIT: if (cnt == CNT_W'(1)) state_next = MR_RESP;
      MR_RESP: state_next = MR_IDLE;
      default: state_next = MR_IDLE;
    endcase
  end

  // The access fires on the edge entering RESP; with a 1-cycle latency that is the acceptance edge.
  always_comb begin
    cnt_next  = cnt;
    acc_we    = 1'b0;
    acc_re    = 1'b0;
    acc_idx   = idx_q;
    acc_wdata = wdata_q;
    acc_be    = be_q;
    if (state == MR_IDLE) begin
      acc_idx   = idx_in;
      acc_wdata = wdata;
      acc_be    = byte_enable;
      if (req) cnt_next = eff_lat - CNT_W'(1);
      if (state_next == MR_RESP) begin
        acc_we = write;
        acc_re = read & ~write;
      end
    end else if (state == MR_WAIT) begin
      cnt_next = cnt - CNT_W'(1);
      if (state_next == MR_RESP) begin
        acc_we = op_wr;
        acc_re = ~op_wr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      op_wr     <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      drop_seen <= 1'b0;
      resp      <= 1'b0;
      busy      <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      cnt       <= cnt_next;
      resp      <= (state_next == MR_RESP);
      busy      <= (state_next != MR_IDLE);
      proto_err <= (accept && read && write) || drop_now;
      if (accept) begin
        op_wr     <= write;
        idx_q     <= idx_in;
        wdata_q   <= wdata;
        be_q      <= byte_enable;
        drop_seen <= 1'b0;
      end else if (drop_now) begin
        drop_seen <= 1'b1;
      end
    end
  end

  mem_resp_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (acc_we),
    .re    (acc_re),
    .be    (acc_be),
    .idx   (acc_idx),
    .wdata (acc_wdata),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed protocol scenarios plus randomized traffic
// against a word/byte-level memory model. Latency checks widen to 4..7 under MEM_RESP_RAND_LAT_EN.
module tb_mem_responder;

  localparam int LAT = 4;
  localparam int MAX_WAIT = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [15:0] address = '0;
  logic [15:0] wdata = '0;
  logic [1:0]  byte_enable = '0;
  logic        resp;
  logic [15:0] rdata;
  logic        busy;
  logic        proto_err;

  mem_responder #(.LATENCY(LAT), .DEPTH_LOG2(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .read        (read),
    .write       (write),
    .address     (address),
    .wdata       (wdata),
    .byte_enable (byte_enable),
    .resp        (resp),
    .rdata       (rdata),
    .busy        (busy),
    .proto_err   (proto_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference: a plain word array, per-byte written flags, and the last value read out.
  logic [15:0] model_mem   [256];
  logic [1:0]  model_valid [256];
  logic [15:0] model_rdata = 16'h0000;
  int          lat_hits [4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_lat(input int lat);
`ifdef MEM_RESP_RAND_LAT_EN
    check("lat_range", 32'(lat >= LAT && lat <= LAT + 3), 32'd1);
    if (lat >= LAT && lat <= LAT + 3) lat_hits[lat-LAT]++;
`else
    check("latency", 32'(lat), 32'(LAT));
`endif
  endtask

  task automatic model_access(input logic rd, input logic wr, input logic [15:0] addr,
                              input logic [15:0] wd, input logic [1:0] be);
    int w;
    w = int'(addr[8:1]);
    if (wr) begin
      if (be[0]) begin model_mem[w][7:0]  = wd[7:0];  model_valid[w][0] = 1'b1; end
      if (be[1]) begin model_mem[w][15:8] = wd[15:8]; model_valid[w][1] = 1'b1; end
    end else if (rd) begin
      model_rdata = model_mem[w];
    end
  endtask

  // One complete transaction from an IDLE cycle back to the next IDLE cycle.
  task automatic txn(input logic rd, input logic wr, input logic [15:0] addr,
                     input logic [15:0] wd, input logic [1:0] be, input bit drop_req);
    int lat;
    bit got_resp;
    @(negedge clk);
    read = rd; write = wr; address = addr; wdata = wd; byte_enable = be;
    @(posedge clk); #1;
    model_access(rd, wr, addr, wd, be);
    lat = 1;
    got_resp = 0;
    while (lat <= MAX_WAIT) begin
      if (resp) begin got_resp = 1; break; end
      check("busy_wait", 32'(busy), 32'd1);
      check("proto_err", 32'(proto_err), 32'((lat == 1 && rd && wr) || (lat == 2 && drop_req)));
      if (drop_req && lat == 1) begin read = 1'b0; write = 1'b0; end
      @(posedge clk); #1;
      lat++;
    end
    if (!got_resp) begin
      check("resp_timeout", 32'd0, 32'd1);
    end else begin
      check_lat(lat);
      check("busy_resp", 32'(busy), 32'd1);
      check("rdata_resp", 32'(rdata), 32'(model_rdata));
    end
    read = 1'b0; write = 1'b0;
    @(posedge clk); #1;
    check("resp_single", 32'(resp), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
    check("rdata_hold", 32'(rdata), 32'(model_rdata));
  endtask

  task automatic back_to_back();
    int cyc, first_at, second_at, n;
    @(negedge clk);
    read = 1'b1; address = 16'h0010;
    cyc = 0; n = 0; first_at = -1; second_at = -1;
    while (cyc < MAX_WAIT && n < 2) begin
      @(posedge clk); #1;
      cyc++;
      if (resp) begin
        n++;
        if (n == 1) begin
          first_at = cyc;
          check("b2b_rdata0", 32'(rdata), 32'h0000BEEF);
          address = 16'h0020;
        end else begin
          second_at = cyc;
          check("b2b_rdata1", 32'(rdata), 32'h0000AB34);
          read = 1'b0;
        end
      end
    end
    check("b2b_count", 32'(n), 32'd2);
`ifdef MEM_RESP_RAND_LAT_EN
    check("b2b_gap", 32'(second_at - first_at >= LAT + 1 && second_at - first_at <= LAT + 4), 32'd1);
`else
    check("b2b_gap", 32'(second_at - first_at), 32'(LAT + 1));
`endif
    read = 1'b0;
    model_rdata = 16'hAB34;
    @(posedge clk); #1;
    check("b2b_idle", 32'(busy), 32'd0);
  endtask

  task automatic reset_mid_write();
    int resp_cnt;
    @(negedge clk);
    write = 1'b1; address = 16'h0010; wdata = 16'h0000; byte_enable = 2'b11;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    write = 1'b0;
    #1;
    check("rst_resp", 32'(resp), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_perr", 32'(proto_err), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    model_rdata = 16'h0000;
    resp_cnt = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (resp) resp_cnt++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      if (resp) resp_cnt++;
    end
    check("rst_no_resp", 32'(resp_cnt), 32'd0);
  endtask

  initial begin
    logic [15:0] a, d;
    logic [1:0]  be;
    int          r, n_rand;
    bit          rd, wr, dr;

    for (int i = 0; i < 256; i++) model_valid[i] = 2'b00;
    for (int i = 0; i < 4; i++) lat_hits[i] = 0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_resp", 32'(resp), 32'd0);
    check("reset_rdata", 32'(rdata), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_perr", 32'(proto_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    txn(1'b0, 1'b1, 16'h0010, 16'hBEEF, 2'b11, 1'b0);
    txn(1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, 1'b0);
    check("read_beef", 32'(model_rdata), 32'h0000BEEF);

    txn(1'b0, 1'b1, 16'h0020, 16'h1234, 2'b11, 1'b0);
    txn(1'b0, 1'b1, 16'h0020, 16'hAB00, 2'b10, 1'b0);
    txn(1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, 1'b0);

    back_to_back();

    txn(1'b1, 1'b1, 16'h0030, 16'h5555, 2'b11, 1'b0);
    txn(1'b1, 1'b0, 16'h0030, 16'h0000, 2'b00, 1'b0);

    txn(1'b0, 1'b1, 16'h0040, 16'h7777, 2'b11, 1'b1);
    txn(1'b1, 1'b0, 16'h0040, 16'h0000, 2'b00, 1'b0);

    reset_mid_write();
    txn(1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, 1'b0);

`ifdef MEM_RESP_RAND_LAT_EN
    n_rand = 1000;
`else
    n_rand = 200;
`endif
    for (int k = 0; k < n_rand; k++) begin
      a = 16'($urandom);
      a[8:1] = 8'($urandom_range(0, 15));
      d = 16'($urandom);
      be = 2'($urandom_range(0, 3));
      r = $urandom_range(0, 9);
      rd = (r < 6) || (r == 9);
      wr = (r >= 6);
      dr = (r == 8);
      if (rd && !wr && model_valid[int'(a[8:1])] != 2'b11) begin
        rd = 1'b0; wr = 1'b1; be = 2'b11;
      end
      txn(rd, wr, a, d, be, dr);
    end

`ifdef MEM_RESP_RAND_LAT_EN
    for (int i = 0; i < 4; i++) check("lat_hit", 32'(lat_hits[i] != 0), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the pipeline's single-outstanding read/write/resp memory protocol. Accepts a request held high by the initiator, latches address/data, waits a programmable latency, performs the access against an internal byte-enabled word array, and pulses `resp` for exactly one cycle. Used as the behavioural/synthesizable memory behind the datapath's stall logic. Usable in benches and FPGA builds in place of physical memory.

## Interface
Parameters:
- `LATENCY`, 4: cycles from request acceptance to `resp`; legal range 1..15.
- `DEPTH_LOG2`, 8: log2 of word count in the array.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `read` in 1: read request, held high by initiator until `resp`.
- `write` in 1: write request, held high by initiator until `resp`.
- `address` in 16: byte address; word index = `address[DEPTH_LOG2:1]`, upper bits ignored.
- `wdata` in 16: write data.
- `byte_enable` in 2: bit0 → `wdata[7:0]`, bit1 → `wdata[15:8]`.
- `resp` out 1: one-cycle completion pulse, registered.
- `rdata` out 16: read data, registered, valid when `resp`=1, held afterwards.
- `busy` out 1: high in WAIT and RESP states.
- `proto_err` out 1: one-cycle pulse, registered; protocol violation detected.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: at an edge with `read|write`=1, latch op, word index, `wdata`, `byte_enable`, and load counter = `LATENCY`-1.
  - `LATENCY`=1 → RESP. Otherwise → WAIT.
- WAIT: counter decrements each edge. Transition at counter=1 → RESP.
- Access on the edge entering RESP:
  - Write: update only enabled bytes; `rdata` unchanged.
  - Read: `rdata` ← array word.
- RESP: `resp`=1 for this cycle only; next edge → IDLE.
- Back-to-back: IDLE samples `read`/`write` in the cycle after RESP. Still-high request = new transaction. No dead cycle beyond IDLE.
- `read`=`write`=1 at acceptance: write performed, read ignored, `proto_err` pulses next cycle.
- Request dropped or inputs changed during WAIT: ignored. Latched transaction completes, `resp` still pulses, `proto_err` pulses one cycle after the drop is first seen.
- Array contents not reset. Reads of never-written words return X in sim.

## Timing
- Reset values: `resp`=0, `rdata`=16'h0000, `busy`=0, `proto_err`=0, state IDLE, counter 0.
- Request high in cycle t (state IDLE) → `resp`=1 in cycle t+`LATENCY`, 0 in t+`LATENCY`+1.
- Max throughput: one transaction per `LATENCY`+1 cycles.
- `busy` rises in cycle t+1 and falls in cycle t+`LATENCY`+1.
- `rst_n` low mid-transaction: immediate return to reset values. Pending write discarded, array not modified. No `resp` issued.
- `rst_n` deassertion: first acceptance possible at the first rising edge after release.

## Configuration
- `MEM_RESP_RAND_LAT_EN` defined: adds an 8-bit Galois LFSR (poly x^8+x^6+x^5+x^4+1, seed 8'hA5 on reset, steps every cycle).
  - Effective latency = `LATENCY` + `lfsr[1:0]`, sampled at acceptance, so latency ranges `LATENCY`..`LATENCY`+3.
  - Counter width covers 18.
- Not defined: latency fixed at `LATENCY`, no LFSR logic.

## Structure
- Package `mem_resp_pkg`: state enum (`MR_IDLE`, `MR_WAIT`, `MR_RESP`), `MR_DATA_W`=16, `MR_ADDR_W`=16, LFSR seed/taps constants.
- Sub-module `mem_resp_array`: synchronous single-port word array.
  - Ports: write enable, 2-bit byte enable, index, wdata, registered rdata.
  - Instantiated once. FSM, counter, LFSR and error logic live in the top module.

## Test plan
- Reset, then write 16'hBEEF to 16'h0010 with `byte_enable`=2'b11, `LATENCY`=4 → `resp` exactly 4 cycles after acceptance, single-cycle. Read 16'h0010 → `rdata`=16'hBEEF with `resp`.
- Write 16'h1234 to 16'h0020 (be=11), then 16'hAB00 with be=2'b10, then read → `rdata`=16'hAB34.
- Back-to-back reads of 16'h0010 and 16'h0020 with `read` held continuously → two `resp` pulses 5 cycles apart, `rdata` 16'hBEEF then 16'hAB34.
- `read`=`write`=1, address 16'h0030, wdata 16'h5555 → `proto_err` pulse the cycle after acceptance. Later read returns 16'h5555.
- Pull `rst_n` low 2 cycles into a write of 16'h0000 to 16'h0010 → `resp` never asserts, outputs at reset values. Read 16'h0010 → 16'hBEEF.
- With `MEM_RESP_RAND_LAT_EN` and 1000 random reads → every `resp` latency within 4..7, all four values observed.
